// File: rtl/conv_channel_accum_param_if.sv
// Pixel stream bundle for conv_channel_accum_param: input beat plus summed output and status.
interface conv_channel_accum_param_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] pxl_in;
    logic [DATA_WIDTH-1:0] pxl_out;
    logic                  valid_out;
    logic                  frame_done;
    logic                  sat_flag;
    logic                  busy;

    modport master (
        output valid_in, pxl_in,
        input  pxl_out, valid_out, frame_done, sat_flag, busy
    );

    modport slave (
        input  valid_in, pxl_in,
        output pxl_out, valid_out, frame_done, sat_flag, busy
    );
endinterface

// File: rtl/conv_channel_accum_param.sv
// Sums channel-major conv partial results into one saturated output plane.
// Define CONV_ACC_RELU_EN to clamp negative sums to zero on the output.
module conv_channel_accum_param #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ACC_WIDTH      = 24,
    parameter int unsigned IMAGE_WIDTH    = 128,
    parameter int unsigned IMAGE_HEIGHT   = 128,
    parameter int unsigned CHANNEL_NUM_IN = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    conv_channel_accum_param_if.slave    bus
);
    localparam int unsigned IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned PIX_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int unsigned CH_W  = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_SIZE - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM_IN - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    logic [PIX_W-1:0]            pix_cnt_q, pix_cnt_d;
    logic [CH_W-1:0]             ch_cnt_q, ch_cnt_d;
    logic [ACC_WIDTH-1:0]        acc_mem [IMAGE_SIZE];
    logic signed [ACC_WIDTH-1:0] s_ext, acc_rd, sum;
    logic [DATA_WIDTH-1:0]       sat_val, pxl_out_q;
    logic                        sat_hit, is_first, is_last, pix_wrap, out_fire;
    logic                        valid_out_q, frame_done_q, sat_flag_q, busy_q, busy;

    assign s_ext    = ACC_WIDTH'($signed(bus.pxl_in));
    assign acc_rd   = $signed(acc_mem[pix_cnt_q]);
    assign is_first = (ch_cnt_q == '0);
    assign is_last  = (ch_cnt_q == CH_LAST);
    assign pix_wrap = (pix_cnt_q == PIX_LAST);
    assign out_fire = bus.valid_in & is_last;
    // First channel overwrites the stale plane, so no clear pass is needed.
    assign sum      = is_first ? s_ext : acc_rd + s_ext;

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        ch_cnt_d  = ch_cnt_q;
        if (bus.valid_in) begin
            if (pix_wrap) begin
                pix_cnt_d = '0;
                ch_cnt_d  = is_last ? '0 : ch_cnt_q + 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        sat_val = sum[DATA_WIDTH-1:0];
        sat_hit = 1'b0;
        if (sum > SAT_MAX) begin
            sat_val = OUT_MAX;
            sat_hit = 1'b1;
        end else if (sum < SAT_MIN) begin
`ifdef CONV_ACC_RELU_EN
            sat_val = '0;
`else
            sat_val = OUT_MIN;
            sat_hit = 1'b1;
`endif
        end
`ifdef CONV_ACC_RELU_EN
        else if (sum[ACC_WIDTH-1]) begin
            sat_val = '0;
        end
`endif
    end

    // Clears with frame_done unless the next frame's first beat lands that same cycle.
    assign busy = (busy_q & ~frame_done_q) | bus.valid_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt_q    <= '0;
            ch_cnt_q     <= '0;
            pxl_out_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            sat_flag_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            ch_cnt_q     <= ch_cnt_d;
            valid_out_q  <= out_fire;
            frame_done_q <= out_fire & pix_wrap;
            sat_flag_q   <= sat_flag_q | (out_fire & sat_hit);
            busy_q       <= busy;
            if (out_fire) pxl_out_q <= sat_val;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.valid_in && !is_last) acc_mem[pix_cnt_q] <= sum;
    end

    assign bus.pxl_out    = pxl_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sat_flag   = sat_flag_q;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_conv_channel_accum_param.sv
// Directed bench for conv_channel_accum_param: 4x4 image, 3 channels, plus a 1-channel instance.
module tb_conv_channel_accum_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    conv_channel_accum_param_if #(.DATA_WIDTH(16)) bus0 ();
    conv_channel_accum_param_if #(.DATA_WIDTH(16)) bus1 ();

    conv_channel_accum_param #(
        .DATA_WIDTH(16), .ACC_WIDTH(24), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM_IN(3)
    ) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

    conv_channel_accum_param #(
        .DATA_WIDTH(16), .ACC_WIDTH(24), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM_IN(1)
    ) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct packed {
        logic [15:0] pxl;
        logic        fd;
        logic        busy;
    } rec_t;

    typedef struct {
        string       name;
        bit          cmode;
        logic [15:0] cval;
        bit          gaps;
        int          mul;
        int          add;
        bit          sat;
    } vec_t;

    rec_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    bit   exp_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("valid_out_timing", {31'd0, bus0.valid_out}, {31'd0, exp_v});
            if (bus0.valid_out) q.push_back('{bus0.pxl_out, bus0.frame_done, bus0.busy});
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
        exp_v = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input bit last);
        bus0.valid_in = 1'b1;
        bus0.pxl_in   = d;
        @(posedge clk);
        #1;
        exp_v = last;
        bus0.valid_in = 1'b0;
    endtask

    task automatic do_reset();
        bus0.valid_in = 1'b0;
        reset = 1'b0;
        idle();
        idle();
        check("rst_pxl_out", {16'd0, bus0.pxl_out}, 32'd0);
        check("rst_valid_out", {31'd0, bus0.valid_out}, 32'd0);
        check("rst_frame_done", {31'd0, bus0.frame_done}, 32'd0);
        check("rst_sat_flag", {31'd0, bus0.sat_flag}, 32'd0);
        check("rst_busy", {31'd0, bus0.busy}, 32'd0);
        reset = 1'b1;
        idle();
    endtask

    task automatic run_frame(input int offset, input bit cmode, input logic [15:0] cval,
                             input bit gaps);
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 16; p++) begin
                if (gaps) repeat ($urandom_range(0, 1)) idle();
                beat(cmode ? cval : 16'(p + c + offset), c == 2);
            end
        end
    endtask

    task automatic check_out(input string name, input int idx, input int mul, input int add,
                             input bit fd, input bit busy);
        if (idx >= q.size()) begin
            check($sformatf("%s_missing[%0d]", name, idx), 32'd0, 32'd1);
        end else begin
            check($sformatf("%s_pxl[%0d]", name, idx), {16'd0, q[idx].pxl},
                  {16'd0, 16'(mul * (idx % 16) + add)});
            check($sformatf("%s_fd[%0d]", name, idx), {31'd0, q[idx].fd}, {31'd0, fd});
            check($sformatf("%s_busy[%0d]", name, idx), {31'd0, q[idx].busy}, {31'd0, busy});
        end
    endtask

    vec_t vecs[5];

    initial begin
        bus0.valid_in = 1'b0;
        bus0.pxl_in   = '0;
        bus1.valid_in = 1'b0;
        bus1.pxl_in   = '0;

        vecs[0] = '{"ramp", 1'b0, 16'h0000, 1'b0, 3, 3, 1'b0};
        vecs[1] = '{"ramp_gaps", 1'b0, 16'h0000, 1'b1, 3, 3, 1'b0};
        vecs[2] = '{"pos_sat", 1'b1, 16'h7000, 1'b0, 0, 'h7FFF, 1'b1};
`ifdef CONV_ACC_RELU_EN
        vecs[3] = '{"neg_sat", 1'b1, 16'h9000, 1'b0, 0, 'h0000, 1'b0};
        vecs[4] = '{"neg_small", 1'b1, 16'hFF9C, 1'b1, 0, 'h0000, 1'b0};
`else
        vecs[3] = '{"neg_sat", 1'b1, 16'h9000, 1'b0, 0, 'h8000, 1'b1};
        vecs[4] = '{"neg_small", 1'b1, 16'hFF9C, 1'b1, 0, 'hFED4, 1'b0};
`endif

        mon_en = 1'b1;
        for (int v = 0; v < 5; v++) begin
            do_reset();
            q.delete();
            run_frame(0, vecs[v].cmode, vecs[v].cval, vecs[v].gaps);
            repeat (3) idle();
            check({vecs[v].name, "_count"}, q.size(), 32'd16);
            for (int i = 0; i < 16; i++)
                check_out(vecs[v].name, i, vecs[v].mul, vecs[v].add, i == 15, i != 15);
            check({vecs[v].name, "_sat_flag"}, {31'd0, bus0.sat_flag}, {31'd0, vecs[v].sat});
        end

        // Back-to-back frames: busy must hold through the first frame's frame_done.
        do_reset();
        q.delete();
        run_frame(0, 1'b0, 16'h0, 1'b0);
        run_frame(1, 1'b0, 16'h0, 1'b0);
        repeat (3) idle();
        check("b2b_count", q.size(), 32'd32);
        for (int i = 0; i < 16; i++) check_out("b2b_f1", i, 3, 3, i == 15, 1'b1);
        for (int i = 16; i < 32; i++) check_out("b2b_f2", i, 3, 6, i == 31, i != 31);

        // Reset mid-frame: partial planes must not leak into the next frame.
        do_reset();
        q.delete();
        for (int k = 0; k < 20; k++) beat(16'((k % 16) + (k / 16)), 1'b0);
        do_reset();
        check("abort_no_output", q.size(), 32'd0);
        run_frame(0, 1'b0, 16'h0, 1'b0);
        repeat (3) idle();
        check("abort_count", q.size(), 32'd16);
        for (int i = 0; i < 16; i++) check_out("abort", i, 3, 3, i == 15, i != 15);
        mon_en = 1'b0;

        // Single-channel instance: each beat passes straight through.
        for (int p = 0; p < 16; p++) begin
            bus1.valid_in = 1'b1;
            bus1.pxl_in   = 16'hFFFB;
            idle();
            bus1.valid_in = 1'b0;
            @(negedge clk);
            check($sformatf("ch1_valid[%0d]", p), {31'd0, bus1.valid_out}, 32'd1);
`ifdef CONV_ACC_RELU_EN
            check($sformatf("ch1_pxl[%0d]", p), {16'd0, bus1.pxl_out}, 32'h0000);
`else
            check($sformatf("ch1_pxl[%0d]", p), {16'd0, bus1.pxl_out}, 32'hFFFB);
`endif
            check($sformatf("ch1_fd[%0d]", p), {31'd0, bus1.frame_done}, {31'd0, p == 15});
        end
        idle();
        @(negedge clk);
        check("ch1_valid_idle", {31'd0, bus1.valid_out}, 32'd0);
        check("ch1_sat_flag", {31'd0, bus1.sat_flag}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
